mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
- Unified-memory interface between the multicycle control FSM/datapath and a single shared instruction/data memory with a req/gnt/rvalid handshake.
- Decodes the FSM's IRWrite/MemWrite/AddrSrc into a bus access.
- Holds the instruction register (instr, old_pc) and the memory data register.
- Drives stall, which gates the FSM state register and datapath enables until the access completes.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT, 255, maximum cycles in REQ+WAIT before declaring a bus error (8-bit counter).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- IRWrite  in  1  from FSM: instruction fetch requested.
- MemWrite  in  1  from FSM: data store requested.
- AddrSrc  in  1  from FSM: 1 selects data address (alu_out).
- pc  in  ADDR_W  current PC.
- alu_out  in  ADDR_W  registered ALU result (data address).
- wdata  in  DATA_W  store data.
- instr  out  DATA_W  instruction register.
- old_pc  out  ADDR_W  PC of the instruction in instr.
- data  out  DATA_W  load data register.
- stall  out  1  hold FSM and datapath enables.
- bus_err  out  1  sticky timeout error.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  DATA_W  read data.

Behaviour:
- Access kind is combinational, in priority order:
  - MemWrite=1: STORE to alu_out, regardless of AddrSrc.
  - else IRWrite=1: FETCH from pc.
  - else AddrSrc=1: LOAD from alu_out.
  - else NONE.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - kind≠NONE → latch bus_addr, bus_we, bus_wdata, kind and pc; go to REQ.
  - kind=NONE → stay in IDLE.
- REQ:
  - bus_req=1; bus_addr/bus_we/bus_wdata held stable.
  - gnt=0 → stay in REQ.
  - gnt=1 with STORE → DONE.
  - gnt=1 with read and rvalid=0 → WAIT.
  - gnt=1 and rvalid=1 in the same cycle → capture rdata, go to DONE.
- WAIT:
  - bus_req=0.
  - rvalid=1 → capture rdata, go to DONE.
  - rvalid=1 outside WAIT (or outside the REQ gnt cycle) is ignored.
- Capture on completion:
  - FETCH: instr←bus_rdata, old_pc←latched pc.
  - LOAD: data←bus_rdata.
  - STORE: no register update.
- DONE: stall=0 for exactly one cycle so the FSM advances; always go to IDLE.
- stall = (kind≠NONE) && state≠DONE. It is 1 in ERR regardless of kind.
- Minimum latency, with gnt and rvalid in the first REQ cycle: 3 cycles (IDLE, REQ, DONE), stall high for 2 of them.
- Back-to-back accesses: the FSM's next request is seen in the IDLE cycle after DONE.
- Timeout counter:
  - Cleared on IDLE→REQ; increments in REQ and WAIT.
  - Reaching TIMEOUT → ERR.
- ERR: bus_req=0, bus_err=1, stall=1; left only by reset.
- Reset (asynchronous, any state, including mid-access) sets:
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - instr=32'h00000013 (NOP), old_pc=0, data=0.
  - bus_err=0, timeout counter=0.
- Inputs changing while in REQ/WAIT do not affect the in-flight access.

Optional Feature:
- Macro: MEM_BRIDGE_PERF_EN.
- When defined, adds output ports:
  - perf_fetches [31:0]
  - perf_loads [31:0]
  - perf_stores [31:0]
  - perf_stall_cycles [31:0]
- Counting rules:
  - Access counters increment on DONE entry for their kind.
  - perf_stall_cycles increments every cycle stall=1.
  - All counters wrap at 2^32 and are reset to 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- FETCH, zero wait: IRWrite=1, pc=0x10, gnt and rvalid in the first REQ cycle, rdata=0x00500093 → instr=0x00500093, old_pc=0x10; stall high 2 cycles then low 1.
- LOAD with waits: AddrSrc=1, alu_out=0x200; gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF → data=0xDEADBEEF; instr unchanged; bus_addr held 0x200 throughout REQ.
- STORE with MemWrite and IRWrite both high: alu_out=0x300, wdata=0x12345678 → bus_we=1, bus_addr=0x300; gnt → DONE; instr and data unchanged.
- Timeout: FETCH with gnt never asserted → ERR after 255 cycles; bus_err=1, stall=1, bus_req=0; persists until reset.
- Reset mid-WAIT: assert reset during WAIT → next edge state IDLE, bus_req=0, instr=0x00000013; a later rvalid pulse is ignored.
- Perf counters (MEM_BRIDGE_PERF_EN defined): FETCH, LOAD, STORE each zero-wait → perf_fetches=1, perf_loads=1, perf_stores=1, perf_stall_cycles=6.

Source files
------------

// File: rtl/mem_bridge.sv
// Bridge between the multicycle control FSM and a shared instruction/data memory (req/gnt/rvalid).
// Define MEM_BRIDGE_PERF_EN to add the fetch/load/store/stall performance counter ports.
module mem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IRWrite,
   input  logic              MemWrite,
   input  logic              AddrSrc,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] old_pc,
   output logic [DATA_W-1:0] data,
   output logic              stall,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
`ifdef MEM_BRIDGE_PERF_EN
   input  logic [DATA_W-1:0] bus_rdata,
   output logic [31:0]       perf_fetches,
   output logic [31:0]       perf_loads,
   output logic [31:0]       perf_stores,
   output logic [31:0]       perf_stall_cycles
`else
   input  logic [DATA_W-1:0] bus_rdata
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      K_NONE,
      K_FETCH,
      K_LOAD,
      K_STORE
   } kind_t;

   localparam logic [DATA_W-1:0] NOP_INSTR   = DATA_W'(32'h0000_0013);
   localparam logic [7:0]        TIMEOUT_CNT = 8'(TIMEOUT);

   state_t              state_q, state_d;
   kind_t               kind_q, kind_d;
   kind_t               req_kind;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]   old_pc_q, old_pc_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                complete;

   // Store wins over fetch, fetch over load, whatever AddrSrc says.
   always_comb begin
      req_kind = K_NONE;
      if (MemWrite) begin
         req_kind = K_STORE;
      end else if (IRWrite) begin
         req_kind = K_FETCH;
      end else if (AddrSrc) begin
         req_kind = K_LOAD;
      end
   end

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      complete = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_kind != K_NONE) begin
               kind_d  = req_kind;
               addr_d  = (req_kind == K_FETCH) ? pc : alu_out;
               we_d    = (req_kind == K_STORE);
               wdata_d = wdata;
               pc_d    = pc;
               cnt_d   = 8'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 8'd1;
            if (bus_gnt) begin
               if (kind_q == K_STORE) begin
                  state_d = S_DONE;
               end else if (bus_rvalid) begin
                  complete = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (bus_rvalid) begin
               complete = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase

      // A completion in the final allowed cycle still counts as a success.
      if ((state_q == S_REQ || state_q == S_WAIT) && state_d != S_DONE && cnt_d == TIMEOUT_CNT) begin
         state_d = S_ERR;
      end
   end

   always_comb begin
      instr_d  = instr_q;
      old_pc_d = old_pc_q;
      data_d   = data_q;
      if (complete) begin
         if (kind_q == K_FETCH) begin
            instr_d  = bus_rdata;
            old_pc_d = pc_q;
         end else if (kind_q == K_LOAD) begin
            data_d = bus_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         kind_q   <= K_NONE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         pc_q     <= '0;
         instr_q  <= NOP_INSTR;
         old_pc_q <= '0;
         data_q   <= '0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         old_pc_q <= old_pc_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
      end
   end

   // An in-flight access always stalls; only the idle state looks at the live request.
   always_comb begin
      case (state_q)
         S_IDLE:  stall = (req_kind != K_NONE);
         S_DONE:  stall = 1'b0;
         default: stall = 1'b1;
      endcase
   end

   assign bus_req   = (state_q == S_REQ);
   assign bus_err   = (state_q == S_ERR);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign instr     = instr_q;
   assign old_pc    = old_pc_q;
   assign data      = data_q;

`ifdef MEM_BRIDGE_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_load_q, perf_load_d;
   logic [31:0] perf_store_q, perf_store_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q;
      perf_load_d  = perf_load_q;
      perf_store_d = perf_store_q;
      perf_stall_d = perf_stall_q;
      if (state_d == S_DONE && state_q != S_DONE) begin
         case (kind_q)
            K_FETCH: perf_fetch_d = perf_fetch_q + 32'd1;
            K_LOAD:  perf_load_d  = perf_load_q + 32'd1;
            K_STORE: perf_store_d = perf_store_q + 32'd1;
            default: ;
         endcase
      end
      if (stall) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_q <= 32'd0;
         perf_load_q  <= 32'd0;
         perf_store_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_load_q  <= perf_load_d;
         perf_store_q <= perf_store_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetches      = perf_fetch_q;
   assign perf_loads        = perf_load_q;
   assign perf_stores       = perf_store_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard testbench for mem_bridge: the bench plays both the control FSM and the memory,
// predicts each access from the access rules, and a monitor checks bus fields and completions.
module tb_mem_bridge;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 255;

   logic              clk = 1'b0;
   logic              reset;
   logic              IRWrite, MemWrite, AddrSrc;
   logic [ADDR_W-1:0] pc, alu_out;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] old_pc;
   logic [DATA_W-1:0] data;
   logic              stall, bus_err, bus_req, bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_gnt, bus_rvalid;
   logic [DATA_W-1:0] bus_rdata;
`ifdef MEM_BRIDGE_PERF_EN
   logic [31:0]       perf_fetches, perf_loads, perf_stores, perf_stall_cycles;
`endif

   mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .reset(reset),
      .IRWrite(IRWrite),
      .MemWrite(MemWrite),
      .AddrSrc(AddrSrc),
      .pc(pc),
      .alu_out(alu_out),
      .wdata(wdata),
      .instr(instr),
      .old_pc(old_pc),
      .data(data),
      .stall(stall),
      .bus_err(bus_err),
      .bus_req(bus_req),
      .bus_we(bus_we),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt),
      .bus_rvalid(bus_rvalid),
`ifdef MEM_BRIDGE_PERF_EN
      .perf_fetches(perf_fetches),
      .perf_loads(perf_loads),
      .perf_stores(perf_stores),
      .perf_stall_cycles(perf_stall_cycles),
`endif
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] instr;
      logic [31:0] oldPc;
      logic [31:0] data;
      int          stallCycles;
   } expect_t;

   expect_t     sbQueue[$];
   int          compareCount = 0;
   int          failCount = 0;
   bit          scoreboardOn = 1'b0;
   logic [31:0] modelInstr, modelOldPc, modelData;
   int          modelFetches, modelLoads, modelStores, modelStall;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic resetModel();
      modelInstr   = 32'h0000_0013;
      modelOldPc   = 32'd0;
      modelData    = 32'd0;
      modelFetches = 0;
      modelLoads   = 0;
      modelStores  = 0;
      modelStall   = 0;
   endtask

   // One FSM request plus the memory's reply; returns in the completion cycle.
   task automatic applyStimulus(input logic irw, input logic mw, input logic asrc,
                                input logic [31:0] pcv, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int gntDelay, input int rvDelay);
      expect_t e;
      bit      isStore, isRead;
      int      waitCycles;
      isStore  = mw;
      isRead   = !mw && (irw || asrc);
      IRWrite  = irw;
      MemWrite = mw;
      AddrSrc  = asrc;
      pc       = pcv;
      alu_out  = alu;
      wdata    = wd;
      if (!isStore && !isRead) begin
         step();
         return;
      end
      e.addr  = (!mw && irw) ? pcv : alu;
      e.we    = isStore;
      e.wdata = wd;
      if (isRead && irw) begin
         modelInstr = rd;
         modelOldPc = pcv;
         modelFetches++;
      end else if (isRead) begin
         modelData = rd;
         modelLoads++;
      end else begin
         modelStores++;
      end
      e.instr       = modelInstr;
      e.oldPc       = modelOldPc;
      e.data        = modelData;
      e.stallCycles = 1 + gntDelay + 1 + (isRead ? rvDelay : 0);
      modelStall   += e.stallCycles;
      sbQueue.push_back(e);

      waitCycles = 0;
      do begin
         step();
         waitCycles++;
      end while (!bus_req && waitCycles < 4);
      if (!bus_req) begin
         checkOutput("bus_req_start", {31'b0, bus_req}, 32'd1);
         IRWrite = 1'b0; MemWrite = 1'b0; AddrSrc = 1'b0;
         return;
      end

      for (int k = 0; k < gntDelay; k++) begin
         bus_gnt    = 1'b0;
         bus_rvalid = ($urandom_range(0, 3) == 0);
         bus_rdata  = $urandom;
         pc         = $urandom;
         alu_out    = $urandom;
         wdata      = $urandom;
         step();
      end
      bus_gnt    = 1'b1;
      bus_rvalid = isStore ? 1'($urandom_range(0, 1)) : (rvDelay == 0);
      bus_rdata  = (isRead && rvDelay == 0) ? rd : $urandom;
      step();
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (isRead && rvDelay > 0) begin
         for (int k = 1; k < rvDelay; k++) begin
            pc        = $urandom;
            alu_out   = $urandom;
            bus_rdata = $urandom;
            step();
         end
         bus_rvalid = 1'b1;
         bus_rdata  = rd;
         step();
         bus_rvalid = 1'b0;
      end
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      AddrSrc  = 1'b0;
   endtask

   // Monitor: checks the held bus fields every request cycle and each completion against the scoreboard.
   bit prevStall = 1'b0;
   int stallRun  = 0;
   always @(negedge clk) begin : monitor
      expect_t e;
      if (reset) begin
         prevStall = 1'b0;
         stallRun  = 0;
      end else begin
         if (stall) stallRun++;
         if (scoreboardOn && bus_req) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_bus_req", {31'b0, bus_req}, 32'd0);
            end else begin
               checkOutput("bus_addr", bus_addr, sbQueue[0].addr);
               checkOutput("bus_we", {31'b0, bus_we}, {31'b0, sbQueue[0].we});
               checkOutput("bus_wdata", bus_wdata, sbQueue[0].wdata);
            end
         end
         if (scoreboardOn && prevStall && !stall) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("instr", instr, e.instr);
               checkOutput("old_pc", old_pc, e.oldPc);
               checkOutput("data", data, e.data);
               checkOutput("stall_cycles", 32'(stallRun), 32'(e.stallCycles));
            end
         end
         if (!stall) stallRun = 0;
         prevStall = stall;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int count;
      reset      = 1'b1;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      AddrSrc    = 1'b0;
      pc         = '0;
      alu_out    = '0;
      wdata      = '0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      resetModel();
      #12;
      checkOutput("reset_instr", instr, 32'h0000_0013);
      checkOutput("reset_old_pc", old_pc, 32'd0);
      checkOutput("reset_data", data, 32'd0);
      checkOutput("reset_bus_req", {31'b0, bus_req}, 32'd0);
      checkOutput("reset_bus_we", {31'b0, bus_we}, 32'd0);
      checkOutput("reset_bus_addr", bus_addr, 32'd0);
      checkOutput("reset_bus_wdata", bus_wdata, 32'd0);
      checkOutput("reset_bus_err", {31'b0, bus_err}, 32'd0);
      checkOutput("reset_stall", {31'b0, stall}, 32'd0);
      step();
      reset = 1'b0;
      step();
      scoreboardOn = 1'b1;

      $display("[TB] zero-wait fetch, load, store");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0050_0093, 0, 0);
      checkOutput("fetch_instr", instr, 32'h0050_0093);
      checkOutput("fetch_old_pc", old_pc, 32'h10);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h14, 32'h104, 32'h0, 32'hCAFE_F00D, 0, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h18, 32'h300, 32'h1234_5678, 32'h5555_AAAA, 0, 0);
      checkOutput("store_instr_kept", instr, 32'h0050_0093);
      checkOutput("store_data_kept", data, 32'hCAFE_F00D);
`ifdef MEM_BRIDGE_PERF_EN
      checkOutput("perf_fetches", perf_fetches, 32'd1);
      checkOutput("perf_loads", perf_loads, 32'd1);
      checkOutput("perf_stores", perf_stores, 32'd1);
      checkOutput("perf_stall_cycles", perf_stall_cycles, 32'd6);
`endif

      $display("[TB] load with gnt and rvalid waits");
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1C, 32'h200, 32'h0, 32'hDEAD_BEEF, 2, 3);
      checkOutput("wait_load_data", data, 32'hDEAD_BEEF);
      checkOutput("wait_load_instr", instr, 32'h0050_0093);

      $display("[TB] randomized accesses");
      for (int n = 0; n < 150; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step();
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, $urandom,
                       $urandom_range(0, 4), $urandom_range(0, 4));
      end
      step();
      checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
`ifdef MEM_BRIDGE_PERF_EN
      checkOutput("perf_fetches_total", perf_fetches, 32'(modelFetches));
      checkOutput("perf_loads_total", perf_loads, 32'(modelLoads));
      checkOutput("perf_stores_total", perf_stores, 32'(modelStores));
      checkOutput("perf_stall_total", perf_stall_cycles, 32'(modelStall));
`endif
      scoreboardOn = 1'b0;

      $display("[TB] timeout with gnt never asserted");
      IRWrite = 1'b1;
      pc      = 32'h40;
      step();
      count = 0;
      while (bus_req && count < 400) begin
         count++;
         step();
      end
      checkOutput("timeout_req_cycles", 32'(count), 32'(TIMEOUT));
      checkOutput("err_bus_err", {31'b0, bus_err}, 32'd1);
      checkOutput("err_stall", {31'b0, stall}, 32'd1);
      checkOutput("err_bus_req", {31'b0, bus_req}, 32'd0);
      IRWrite    = 1'b0;
      bus_gnt    = 1'b1;
      bus_rvalid = 1'b1;
      for (int k = 0; k < 5; k++) step();
      checkOutput("err_sticky_bus_err", {31'b0, bus_err}, 32'd1);
      checkOutput("err_sticky_stall", {31'b0, stall}, 32'd1);
      checkOutput("err_sticky_bus_req", {31'b0, bus_req}, 32'd0);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("err_reset_bus_err", {31'b0, bus_err}, 32'd0);
      checkOutput("err_reset_stall", {31'b0, stall}, 32'd0);
      resetModel();
      step();
      reset = 1'b0;
      step();

      $display("[TB] reset in the middle of a read wait");
      scoreboardOn = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'hA5A5_0F0F, 1, 1);
      step();
      scoreboardOn = 1'b0;
      AddrSrc = 1'b1;
      alu_out = 32'h400;
      count = 0;
      do begin
         step();
         count++;
      end while (!bus_req && count < 4);
      checkOutput("midwait_req_seen", {31'b0, bus_req}, 32'd1);
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      checkOutput("midwait_req_dropped", {31'b0, bus_req}, 32'd0);
      checkOutput("midwait_stall", {31'b0, stall}, 32'd1);
      step();
      #2;
      reset   = 1'b1;
      AddrSrc = 1'b0;
      #1;
      checkOutput("midwait_reset_instr", instr, 32'h0000_0013);
      checkOutput("midwait_reset_bus_req", {31'b0, bus_req}, 32'd0);
      checkOutput("midwait_reset_stall", {31'b0, stall}, 32'd0);
      checkOutput("midwait_reset_bus_addr", bus_addr, 32'd0);
      step();
      reset      = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hBADC_0DE5;
      step();
      step();
      bus_rvalid = 1'b0;
      checkOutput("late_rvalid_data", data, 32'd0);
      checkOutput("late_rvalid_instr", instr, 32'h0000_0013);
      checkOutput("late_rvalid_stall", {31'b0, stall}, 32'd0);
      checkOutput("late_rvalid_bus_req", {31'b0, bus_req}, 32'd0);
      checkOutput("late_rvalid_bus_err", {31'b0, bus_err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
